// File: rtl/icache_pkg.sv
// Shared types and helpers for the SM instruction-cache controller.
// Default geometry, the FSM state encoding and line-address field extraction.
package icache_pkg;

  localparam int TAG_WIDTH_DEF = 7;
  localparam int SET_WIDTH_DEF = 5;
  localparam int NUM_WAY_DEF   = 2;
  localparam int WAY_DEPTH_DEF = 1;
  localparam int NUM_SET       = 2 ** SET_WIDTH_DEF;

  typedef logic [TAG_WIDTH_DEF+SET_WIDTH_DEF-1:0] line_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_REQ,
    ST_MISS_WAIT,
    ST_REPLAY
  } state_t;

  function automatic logic [TAG_WIDTH_DEF-1:0] get_tag(input line_addr_t addr);
    return addr[TAG_WIDTH_DEF+SET_WIDTH_DEF-1 -: TAG_WIDTH_DEF];
  endfunction

  function automatic logic [SET_WIDTH_DEF-1:0] get_set(input line_addr_t addr);
    return addr[SET_WIDTH_DEF-1:0];
  endfunction

endpackage

// File: rtl/tag_checker_icache.sv
// Parallel tag compare across the ways of one set.
// Returns a hit flag and the binary index of the matching valid way.
module tag_checker_icache
  import icache_pkg::*;
#(
  parameter int TAG_WIDTH = TAG_WIDTH_DEF,
  parameter int NUM_WAY   = NUM_WAY_DEF,
  parameter int WAY_DEPTH = WAY_DEPTH_DEF
) (
  input  logic [TAG_WIDTH-1:0]              tag,
  input  logic [NUM_WAY-1:0][TAG_WIDTH-1:0] way_tags,
  input  logic [NUM_WAY-1:0]                way_valid,
  output logic                              hit,
  output logic [WAY_DEPTH-1:0]              way
);

  always_comb begin
    hit = 1'b0;
    way = '0;
    for (int w = 0; w < NUM_WAY; w++) begin
      if (way_valid[w] && (way_tags[w] == tag)) begin
        hit = 1'b1;
        way = WAY_DEPTH'(w);
      end
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// Instruction-cache lookup/miss controller: owns tags, valid bits and LRU pointers,
// sequences hits, line fills from memory, refill writes and whole-cache flushes.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int TAG_WIDTH = TAG_WIDTH_DEF,
  parameter int SET_WIDTH = SET_WIDTH_DEF,
  parameter int NUM_WAY   = NUM_WAY_DEF,
  parameter int WAY_DEPTH = WAY_DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           core_req_valid_i,
  output logic                           core_req_ready_o,
  input  logic [TAG_WIDTH+SET_WIDTH-1:0] core_req_addr_i,
  output logic                           core_rsp_valid_o,
  output logic [SET_WIDTH-1:0]           core_rsp_set_o,
  output logic [WAY_DEPTH-1:0]           core_rsp_way_o,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic [TAG_WIDTH+SET_WIDTH-1:0] mem_req_addr_o,
  input  logic                           mem_rsp_valid_i,
  output logic                           data_we_o,
  output logic [SET_WIDTH-1:0]           data_set_o,
  output logic [WAY_DEPTH-1:0]           data_way_o,
  input  logic                           flush_i,
  output logic                           busy_o
);

  localparam int ADDR_W = TAG_WIDTH + SET_WIDTH;
  localparam int SETS   = 2 ** SET_WIDTH;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  state_t                           state;
  logic [ADDR_W-1:0]                addr_q;
  logic [WAY_DEPTH-1:0]             victim_q;
  logic                             flush_pending;
  logic [NUM_WAY-1:0]               valid_q [SETS];
  logic [WAY_DEPTH-1:0]             ptr_q   [SETS];
  logic [NUM_WAY-1:0][TAG_WIDTH-1:0] tag_q  [SETS];

  logic [SET_WIDTH-1:0] set_q;
  logic [TAG_WIDTH-1:0] req_tag;
  logic                 hit;
  logic [WAY_DEPTH-1:0] hit_way;
  logic [WAY_DEPTH-1:0] victim;
  logic                 req_fire;
  logic                 refill;

  assign set_q   = addr_q[SET_WIDTH-1:0];
  assign req_tag = addr_q[ADDR_W-1 -: TAG_WIDTH];

  tag_checker_icache #(
    .TAG_WIDTH (TAG_WIDTH),
    .NUM_WAY   (NUM_WAY),
    .WAY_DEPTH (WAY_DEPTH)
  ) u_tag_checker (
    .tag       (req_tag),
    .way_tags  (tag_q[set_q]),
    .way_valid (valid_q[set_q]),
    .hit       (hit),
    .way       (hit_way)
  );

  function automatic logic [WAY_DEPTH-1:0] next_way(input logic [WAY_DEPTH-1:0] w);
    return (int'(w) == NUM_WAY - 1) ? '0 : w + 1'b1;
  endfunction

  // Lowest-index invalid way wins; fall back to the LRU pointer when the set is full.
  always_comb begin
    victim = ptr_q[set_q];
    for (int w = NUM_WAY - 1; w >= 0; w--) begin
      if (!valid_q[set_q][w]) victim = WAY_DEPTH'(w);
    end
  end

  assign core_req_ready_o = ((state == ST_IDLE) || ((state == ST_LOOKUP) && hit))
                            && !flush_pending && !flush_i;
  assign req_fire         = core_req_valid_i && core_req_ready_o;
  assign refill           = (state == ST_MISS_WAIT) && mem_rsp_valid_i;

  assign core_rsp_valid_o = ((state == ST_LOOKUP) && hit) || (state == ST_REPLAY);
  assign core_rsp_set_o   = set_q;
  assign core_rsp_way_o   = (state == ST_REPLAY) ? victim_q : hit_way;
  assign data_we_o        = refill;
  assign data_set_o       = set_q;
  assign data_way_o       = victim_q;
  assign busy_o           = (state != ST_IDLE) || flush_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      addr_q          <= '0;
      victim_q        <= '0;
      flush_pending   <= 1'b0;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      if (flush_i) flush_pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (req_fire) begin
            addr_q <= core_req_addr_i;
            state  <= ST_LOOKUP;
          end else if (flush_pending) begin
            for (int s = 0; s < SETS; s++) begin
              valid_q[s] <= '0;
              ptr_q[s]   <= '0;
            end
            flush_pending <= flush_i;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            ptr_q[set_q] <= next_way(hit_way);
            if (req_fire) addr_q <= core_req_addr_i;
            else          state  <= ST_IDLE;
          end else begin
            victim_q        <= victim;
            mem_req_valid_o <= 1'b1;
            mem_req_addr_o  <= addr_q;
            state           <= ST_MISS_REQ;
          end
        end
        ST_MISS_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            state           <= ST_MISS_WAIT;
          end
        end
        ST_MISS_WAIT: begin
          if (mem_rsp_valid_i) begin
            valid_q[set_q][victim_q] <= 1'b1;
            ptr_q[set_q]             <= next_way(victim_q);
            state                    <= ST_REPLAY;
          end
        end
        ST_REPLAY: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Tag storage is not reset; the valid bits guard it.
  always_ff @(posedge clk) begin
    if (refill) tag_q[set_q][victim_q] <= req_tag;
  end

endmodule
